// File: rtl/vtracer_pkg.sv
// Shared widths, fixed-point unit and FSM encoding for the vector normalizer.
package vtracer_pkg;

    localparam int VT_W    = 20;
    localparam int VT_FRAC = 14;
    localparam int VT_OW   = VT_FRAC + 2;
    localparam int VT_UNIT = 1 << VT_FRAC;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DIV  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

endpackage

// File: rtl/norm_div_lane.sv
// One component lane: |c| * 2^FRAC / mold by restoring division, MSB first,
// with saturation to +/-1.0 and sign restore on the output.
module norm_div_lane #(
    parameter int W    = 20,
    parameter int FRAC = 14,
    parameter int OW   = FRAC + 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load,
    input  logic          step,
    input  logic [W-1:0]  c,
    input  logic [W-1:0]  mold,
    input  logic          zero,
    output logic [OW-1:0] res
);

    logic          neg_q, neg_d;
    logic          sat_q, sat_d;
    logic [W:0]    rem_q, rem_d;
    logic [FRAC:0] quo_q, quo_d;

    logic [W:0]    c_ext;
    logic [W:0]    abs_c;
    logic [W:0]    mold_ext;
    logic [W:0]    diff;
    logic          ge;
    logic [OW-1:0] mag;

    always_comb begin
        c_ext    = {c[W-1], c};
        abs_c    = c[W-1] ? ('0 - c_ext) : c_ext;
        mold_ext = {1'b0, mold};
        diff     = rem_q - mold_ext;
        ge       = (rem_q >= mold_ext);

        neg_d = neg_q;
        sat_d = sat_q;
        rem_d = rem_q;
        quo_d = quo_q;

        if (load) begin
            neg_d = c[W-1];
            sat_d = (abs_c > mold_ext) && (mold != '0);
            rem_d = sat_d ? '0 : abs_c;
            quo_d = '0;
        end else if (step) begin
            // remainder stays below mold after each step, so dropping bit W is lossless
            rem_d = ge ? {diff[W-1:0], 1'b0} : {rem_q[W-1:0], 1'b0};
            quo_d = {quo_q[FRAC-1:0], ge};
        end
    end

    always_comb begin
        if (zero) begin
            mag = '0;
        end else if (sat_q) begin
            mag = OW'(1) << FRAC;
        end else begin
            mag = OW'(quo_q);
        end
        res = neg_q ? ('0 - mag) : mag;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            neg_q <= 1'b0;
            sat_q <= 1'b0;
            rem_q <= '0;
            quo_q <= '0;
        end else begin
            neg_q <= neg_d;
            sat_q <= sat_d;
            rem_q <= rem_d;
            quo_q <= quo_d;
        end
    end

endmodule

// File: rtl/vec_normalize.sv
// Normalizes (x, y, z) by an upstream magnitude; three division lanes share
// one iteration counter and a fixed-latency IDLE/DIV/DONE handshake FSM.
module vec_normalize
    import vtracer_pkg::*;
#(
    parameter int W    = VT_W,
    parameter int FRAC = VT_FRAC,
    parameter int OW   = FRAC + 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [W-1:0]  x,
    input  logic [W-1:0]  y,
    input  logic [W-1:0]  z,
    input  logic [W-1:0]  mold,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [OW-1:0] nx,
    output logic [OW-1:0] ny,
    output logic [OW-1:0] nz,
    output logic          out_zero
);

    localparam int CW = $clog2(FRAC + 1);

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [W-1:0]  mold_q, mold_d;
    logic          zero_q, zero_d;
    logic          load;
    logic          step;
    logic [W-1:0]  lane_mold;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        mold_d  = mold_q;
        zero_d  = zero_q;
        load    = 1'b0;
        step    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    load    = 1'b1;
                    mold_d  = mold;
                    zero_d  = (mold == '0);
                    cnt_d   = '0;
                    state_d = ST_DIV;
                end
            end
            ST_DIV: begin
                step = 1'b1;
                if (cnt_q == CW'(FRAC)) begin
                    state_d = ST_DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign in_ready  = (state_q == ST_IDLE);
    assign out_valid = (state_q == ST_DONE);
    assign out_zero  = zero_q;
    // lanes see the live magnitude only on the acceptance cycle
    assign lane_mold = load ? mold : mold_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            mold_q  <= '0;
            zero_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            mold_q  <= mold_d;
            zero_q  <= zero_d;
        end
    end

    norm_div_lane #(.W(W), .FRAC(FRAC), .OW(OW)) u_lane_x (
        .clk(clk), .rst(rst), .load(load), .step(step),
        .c(x), .mold(lane_mold), .zero(zero_q), .res(nx)
    );

    norm_div_lane #(.W(W), .FRAC(FRAC), .OW(OW)) u_lane_y (
        .clk(clk), .rst(rst), .load(load), .step(step),
        .c(y), .mold(lane_mold), .zero(zero_q), .res(ny)
    );

    norm_div_lane #(.W(W), .FRAC(FRAC), .OW(OW)) u_lane_z (
        .clk(clk), .rst(rst), .load(load), .step(step),
        .c(z), .mold(lane_mold), .zero(zero_q), .res(nz)
    );

endmodule
